// File: rtl/seg7_scan_decoder.sv
// Recovers hex nibbles from a multiplexed active-low 7-segment bus, one slot per digit strobe.
// Latency: capture STABLE_CYCLES+1 edges after a held change, outputs one edge later; no backpressure.
// Optional decimal-point tracking is enabled with the SEG7_DECODE_DP_EN macro.
module seg7_scan_decoder #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 8,
    parameter int IDXW          = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg_n,
    input  logic [DIGITS-1:0]     an_n,
`ifdef SEG7_DECODE_DP_EN
    input  logic                  dp_n,
    output logic [DIGITS-1:0]     dp,
`endif
    output logic [4*DIGITS-1:0]   digits,
    output logic [DIGITS-1:0]     valid,
    output logic [DIGITS-1:0]     blank,
    output logic                  upd,
    output logic [IDXW-1:0]       upd_idx,
    output logic                  err
);

`ifdef SEG7_DECODE_DP_EN
    localparam int SW = DIGITS + 8;
`else
    localparam int SW = DIGITS + 7;
`endif

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_HOLD   = 2'd2;

    localparam logic [7:0] STABLE_TGT = 8'(STABLE_CYCLES);

    logic [SW-1:0]        w_in;
    logic [SW-1:0]        r_s_q;
    logic [7:0]           r_cnt;
    logic [7:0]           w_cnt_nxt;
    logic                 w_same;
    logic [DIGITS-1:0]    w_an_low;
    logic                 w_onehot;
    logic [IDXW-1:0]      w_idx;
    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic                 w_capture;

    logic                 r_cap_vld;
    logic [IDXW-1:0]      r_cap_idx;
    logic [6:0]           r_cap_seg;

    logic [3:0]           w_dec_nib;
    logic                 w_dec_legal;
    logic                 w_dec_blank;

    logic [4*DIGITS-1:0]  r_digits;
    logic [DIGITS-1:0]    r_valid;
    logic [DIGITS-1:0]    r_blank;
    logic                 r_upd;
    logic [IDXW-1:0]      r_upd_idx;
    logic                 r_err;

`ifdef SEG7_DECODE_DP_EN
    logic                 r_cap_dpn;
    logic [DIGITS-1:0]    r_dp;
    assign w_in = {dp_n, an_n, seg_n};
`else
    assign w_in = {an_n, seg_n};
`endif

    // The stability run counts the incoming sample, so a change landing on the
    // capture edge itself breaks the run and suppresses that capture.
    assign w_same    = (w_in == r_s_q);
    assign w_cnt_nxt = !w_same ? 8'd0 : ((r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1);

    assign w_an_low = ~w_in[7 +: DIGITS];
    assign w_onehot = (w_an_low != '0) && ((w_an_low & (w_an_low - DIGITS'(1))) == '0);

    always_comb begin
        w_idx = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (w_an_low[k]) begin
                w_idx = IDXW'(k);
            end
        end
    end

    assign w_capture = (r_state == S_SETTLE) && w_same && w_onehot && (w_cnt_nxt == STABLE_TGT);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_onehot) begin
                    w_state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (!w_same || !w_onehot) begin
                    w_state_nxt = S_IDLE;
                end else if (w_cnt_nxt == STABLE_TGT) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!w_same) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s_q     <= '1;
            r_cnt     <= 8'd0;
            r_state   <= S_IDLE;
            r_cap_vld <= 1'b0;
            r_cap_idx <= '0;
            r_cap_seg <= 7'h7F;
        end else begin
            r_s_q     <= w_in;
            r_cnt     <= w_cnt_nxt;
            r_state   <= w_state_nxt;
            r_cap_vld <= w_capture;
            if (w_capture) begin
                r_cap_idx <= w_idx;
                r_cap_seg <= w_in[6:0];
            end
        end
    end

`ifdef SEG7_DECODE_DP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cap_dpn <= 1'b1;
        end else if (w_capture) begin
            r_cap_dpn <= w_in[SW-1];
        end
    end
`endif

    always_comb begin
        w_dec_nib   = 4'h0;
        w_dec_legal = 1'b1;
        w_dec_blank = 1'b0;
        case (r_cap_seg)
            7'h40: w_dec_nib = 4'h0;
            7'h79: w_dec_nib = 4'h1;
            7'h24: w_dec_nib = 4'h2;
            7'h30: w_dec_nib = 4'h3;
            7'h19: w_dec_nib = 4'h4;
            7'h12: w_dec_nib = 4'h5;
            7'h02: w_dec_nib = 4'h6;
            7'h78: w_dec_nib = 4'h7;
            7'h00: w_dec_nib = 4'h8;
            7'h10: w_dec_nib = 4'h9;
            7'h08: w_dec_nib = 4'hA;
            7'h03: w_dec_nib = 4'hB;
            7'h27: w_dec_nib = 4'hC;
            7'h21: w_dec_nib = 4'hD;
            7'h06: w_dec_nib = 4'hE;
            7'h0E: w_dec_nib = 4'hF;
            7'h7F: begin
                w_dec_legal = 1'b0;
                w_dec_blank = 1'b1;
            end
            default: w_dec_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digits  <= '0;
            r_valid   <= '0;
            r_blank   <= '0;
            r_upd     <= 1'b0;
            r_upd_idx <= '0;
            r_err     <= 1'b0;
        end else begin
            r_upd <= r_cap_vld;
            r_err <= r_cap_vld && !w_dec_legal && !w_dec_blank;
            if (r_cap_vld) begin
                r_upd_idx <= r_cap_idx;
                for (int k = 0; k < DIGITS; k++) begin
                    if (r_cap_idx == IDXW'(k)) begin
                        r_valid[k] <= w_dec_legal;
                        r_blank[k] <= w_dec_blank;
                        if (w_dec_legal) begin
                            r_digits[4*k +: 4] <= w_dec_nib;
                        end
                    end
                end
            end
        end
    end

`ifdef SEG7_DECODE_DP_EN
    // Blank and illegal captures still refresh the decimal point of their slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dp <= '0;
        end else if (r_cap_vld) begin
            for (int k = 0; k < DIGITS; k++) begin
                if (r_cap_idx == IDXW'(k)) begin
                    r_dp[k] <= ~r_cap_dpn;
                end
            end
        end
    end

    assign dp = r_dp;
`endif

    assign digits  = r_digits;
    assign valid   = r_valid;
    assign blank   = r_blank;
    assign upd     = r_upd;
    assign upd_idx = r_upd_idx;
    assign err     = r_err;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder (DIGITS=4, STABLE_CYCLES=4).
// Expected captures are queued when a pattern is driven and compared when upd fires.
module tb_seg7_scan_decoder;

    localparam int DIGITS = 4;
    localparam int STABLE = 4;

    logic        clk;
    logic        rst_n;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic [15:0] digits;
    logic [3:0]  valid;
    logic [3:0]  blank;
    logic        upd;
    logic [1:0]  upd_idx;
    logic        err;
`ifdef SEG7_DECODE_DP_EN
    logic        dp_n;
    logic [3:0]  dp;
    logic [3:0]  m_dp;
`endif

    seg7_scan_decoder #(
        .DIGITS        (DIGITS),
        .STABLE_CYCLES (STABLE)
    ) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .seg_n   (seg_n),
        .an_n    (an_n),
`ifdef SEG7_DECODE_DP_EN
        .dp_n    (dp_n),
        .dp      (dp),
`endif
        .digits  (digits),
        .valid   (valid),
        .blank   (blank),
        .upd     (upd),
        .upd_idx (upd_idx),
        .err     (err)
    );

    typedef struct {
        int          cyc;
        int          idx;
        logic        err;
        logic [15:0] dig;
        logic [3:0]  vld;
        logic [3:0]  blk;
`ifdef SEG7_DECODE_DP_EN
        logic [3:0]  dpv;
`endif
    } exp_t;

    exp_t        q[$];
    int          cyc;
    int          n_cmp;
    int          n_bad;
    int          n_upd;
    logic [15:0] m_dig;
    logic [3:0]  m_vld;
    logic [3:0]  m_blk;
    logic [6:0]  tbl [16];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive a pattern; when a capture is expected, update the model and queue its outcome.
    task automatic apply(input logic [3:0] an, input logic [6:0] seg, input int n, input bit cap);
        exp_t e;
        int   idx;
        int   nib;
        an_n  = an;
        seg_n = seg;
        if (cap) begin
            idx = 0;
            for (int k = 0; k < DIGITS; k++) if (!an[k]) idx = k;
            nib = -1;
            for (int v = 0; v < 16; v++) if (tbl[v] == seg) nib = v;
            e.err = 1'b0;
            if (nib >= 0) begin
                m_dig[4*idx +: 4] = 4'(nib);
                m_vld[idx] = 1'b1;
                m_blk[idx] = 1'b0;
            end else if (seg == 7'h7F) begin
                m_vld[idx] = 1'b0;
                m_blk[idx] = 1'b1;
            end else begin
                m_vld[idx] = 1'b0;
                m_blk[idx] = 1'b0;
                e.err = 1'b1;
            end
`ifdef SEG7_DECODE_DP_EN
            m_dp[idx] = ~dp_n;
            e.dpv = m_dp;
`endif
            e.cyc = cyc + STABLE + 2;
            e.idx = idx;
            e.dig = m_dig;
            e.vld = m_vld;
            e.blk = m_blk;
            q.push_back(e);
        end
        step(n);
    endtask

    always @(negedge clk) begin
        if (rst_n && upd) begin
            exp_t e;
            n_upd++;
            check("upd_expected", 32'(q.size() != 0), 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                check("upd_cycle", cyc, e.cyc);
                check("upd_idx", 32'(upd_idx), e.idx);
                check("err", 32'(err), 32'(e.err));
                check("digits", 32'(digits), 32'(e.dig));
                check("valid", 32'(valid), 32'(e.vld));
                check("blank", 32'(blank), 32'(e.blk));
`ifdef SEG7_DECODE_DP_EN
                check("dp", 32'(dp), 32'(e.dpv));
`endif
            end
        end
        if (err && !upd) check("err_without_upd", 32'(err), 0);
    end

    initial begin
        int base;
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E};
        cyc   = 0;
        n_cmp = 0;
        n_bad = 0;
        n_upd = 0;
        m_dig = '0;
        m_vld = '0;
        m_blk = '0;
        rst_n = 1'b0;
        an_n  = 4'hF;
        seg_n = 7'h7F;
`ifdef SEG7_DECODE_DP_EN
        dp_n  = 1'b1;
        m_dp  = '0;
`endif
        step(3);
        check("rst_digits", 32'(digits), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_blank", 32'(blank), 0);
        check("rst_upd", 32'(upd), 0);
        check("rst_upd_idx", 32'(upd_idx), 0);
        check("rst_err", 32'(err), 0);
        rst_n = 1'b1;
        step(2);

        // Single digit: '2' on slot 1, upd six edges after the change.
        apply(4'b1101, 7'h24, 8, 1);
        check("d1_nibble", 32'(digits[7:4]), 2);
        check("d1_valid", 32'(valid), 32'(4'b0010));

        // Full scan of four digits.
        base = n_upd;
        apply(4'b1110, 7'h40, 6, 1);
        apply(4'b1101, 7'h79, 6, 1);
        apply(4'b1011, 7'h0E, 6, 1);
        apply(4'b0111, 7'h21, 6, 1);
        step(1);
        check("scan_digits", 32'(digits), 32'(16'hDF10));
        check("scan_valid", 32'(valid), 32'(4'hF));
        check("scan_upd_count", n_upd - base, 4);

        // Blank keeps the old nibble; an illegal pattern raises err.
        apply(4'b1110, 7'h7F, 8, 1);
        check("blank0", 32'(blank[0]), 1);
        check("blank_valid0", 32'(valid[0]), 0);
        check("blank_keeps_nib", 32'(digits[3:0]), 0);
        apply(4'b1110, 7'h55, 8, 1);
        check("illegal_valid0", 32'(valid[0]), 0);
        check("illegal_blank0", 32'(blank[0]), 0);

        // Toggling faster than the settle window never captures; then one hold.
        base = n_upd;
        for (int i = 0; i < 6; i++) apply(4'b1011, (i % 2 == 0) ? 7'h30 : 7'h19, 3, 0);
        apply(4'b1011, 7'h12, 20, 1);
        check("toggle_one_upd", n_upd - base, 1);

        // A change landing exactly on the capture edge suppresses it.
        base = n_upd;
        apply(4'b0111, 7'h02, 4, 0);
        apply(4'b0111, 7'h78, 8, 1);
        check("capture_edge_upd", n_upd - base, 1);

        // Multi-low and all-high strobes are ignored.
        base = n_upd;
        apply(4'b1100, 7'h00, 20, 0);
        apply(4'b1111, 7'h00, 20, 0);
        check("nonhot_upd", n_upd - base, 0);
        check("nonhot_digits", 32'(digits), 32'(m_dig));
        check("nonhot_valid", 32'(valid), 32'(m_vld));
        check("nonhot_blank", 32'(blank), 32'(m_blk));

        // Reset two edges after a capture edge clears outputs immediately.
`ifdef SEG7_DECODE_DP_EN
        dp_n = 1'b0;
`endif
        apply(4'b0111, 7'h00, STABLE + 3, 1);
        an_n  = 4'hF;
        rst_n = 1'b0;
        #1;
        check("arst_digits", 32'(digits), 0);
        check("arst_valid", 32'(valid), 0);
        check("arst_upd", 32'(upd), 0);
        m_dig = '0;
        m_vld = '0;
        m_blk = '0;
`ifdef SEG7_DECODE_DP_EN
        check("arst_dp", 32'(dp), 0);
        m_dp = '0;
`endif
        step(2);
        rst_n = 1'b1;
        step(2);

        // Digit 3 shows '8' (with the decimal point lit when tracked).
        apply(4'b0111, 7'h00, 8, 1);
        check("d3_nibble", 32'(digits[15:12]), 8);
`ifdef SEG7_DECODE_DP_EN
        check("d3_dp", 32'(dp), 32'(4'b1000));
        dp_n = 1'b1;
`endif
        apply(4'b1111, 7'h7F, 4, 0);
        check("queue_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
